// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: hazard FSM states and the latch control bundle
// driven by the hazard unit.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      HALTED   = 2'd2
   } hazard_state_t;

   // One bit per PC/latch enable plus the latch flushes; flushes only ever
   // appear together with the matching enable.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_FREEZE = '{
      pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
      memwb_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};

   localparam pipe_ctrl_t CTRL_ADVANCE = '{
      pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
      memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};

   // Taken branch/jump: squash the two wrong-path instructions behind EX/MEM.
   localparam pipe_ctrl_t CTRL_REDIRECT = '{
      pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
      memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0};

   // Load-use bubble: hold PC and IF/ID, inject a nop into ID/EX.
   localparam pipe_ctrl_t CTRL_BUBBLE = '{
      pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1,
      memwb_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0};

   // Instruction fetch not ready: hold PC, feed a nop into IF/ID.
   localparam pipe_ctrl_t CTRL_FETCH_WAIT = '{
      pc_en: 1'b0, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
      memwb_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0};

   function automatic logic is_load_use(
      input logic       dmem_ren,
      input logic       reg_wen,
      input logic [4:0] dest_rt,
      input logic [4:0] src_rs,
      input logic [4:0] src_rt,
      input logic       uses_rt
   );
      return dmem_ren & reg_wen & (dest_rt != 5'd0) &
             ((dest_rt == src_rs) | (uses_rt & (dest_rt == src_rt)));
   endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard unit performance counters; sticks
// at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != MAX)) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, memory-wait freezes, branch/jump
// redirects and halt, plus saturating stall/flush performance counters.
module hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             idex_dMemREN,
   input  logic             idex_regWEN,
   input  logic [4:0]       idex_rt,
   input  logic             redirect,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] BUBBLES_AFTER_FIRST = 2'(LOAD_BUBBLES - 1);

   hazard_state_t state_q, state_d;
   logic [1:0]    bcnt_q, bcnt_d;
   pipe_ctrl_t    ctrl;
   logic          mem_busy;
   logic          lu_hit;
   logic          redirect_taken;
   logic          stall_inc;

   assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
   assign lu_hit   = is_load_use(idex_dMemREN, idex_regWEN, idex_rt,
                                 ifid_rs, ifid_rt, ifid_uses_rt);

   always_comb begin
      state_d        = state_q;
      bcnt_d         = bcnt_q;
      ctrl           = CTRL_FREEZE;
      redirect_taken = 1'b0;
      if (nRST) begin
         unique case (state_q)
            HALTED: begin
               ctrl = CTRL_FREEZE;
            end
            RUN, LU_STALL: begin
               if (memwb_halt) begin
                  state_d = HALTED;
               end else if (mem_busy) begin
                  ctrl = CTRL_FREEZE;
               end else if (redirect) begin
                  // Redirect beats load-use: the dependent instruction is wrong-path.
                  ctrl           = CTRL_REDIRECT;
                  redirect_taken = 1'b1;
                  state_d        = RUN;
                  bcnt_d         = 2'd0;
               end else if (state_q == LU_STALL) begin
                  ctrl = CTRL_BUBBLE;
                  if (bcnt_q <= 2'd1) begin
                     state_d = RUN;
                     bcnt_d  = 2'd0;
                  end else begin
                     bcnt_d = bcnt_q - 2'd1;
                  end
               end else if (lu_hit) begin
                  ctrl = CTRL_BUBBLE;
                  if (LOAD_BUBBLES > 1) begin
                     state_d = LU_STALL;
                     bcnt_d  = BUBBLES_AFTER_FIRST;
                  end
               end else if (!ihit) begin
                  ctrl = CTRL_FETCH_WAIT;
               end else begin
                  ctrl = CTRL_ADVANCE;
               end
            end
            default: begin
               state_d = RUN;
               bcnt_d  = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         bcnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Memory freezes and the halt-entry cycle count as stalls; halted cycles do not.
   assign stall_inc = nRST & (state_q != HALTED) & ~ctrl.pc_en;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (redirect_taken),
      .count (flush_events)
   );

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign idex_en     = ctrl.idex_en;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_flush = 1'b0;
   assign halt        = (state_q == HALTED);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (1 bubble, 2 bubbles, 2-bit counters)
// share inputs and are checked against a bubbles-remaining reference model.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, exmem_dREN, exmem_dWEN;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_dMemREN, idex_regWEN, redirect, memwb_halt;

  logic [2:0] pc_en_w, ifid_en_w, idex_en_w, exmem_en_w, memwb_en_w;
  logic [2:0] ifid_flush_w, idex_flush_w, exmem_flush_w, halt_w;
  logic [1:0] state_w0, state_w1, state_w2;
  logic [31:0] stall_w0, stall_w1, flush_w0, flush_w1;
  logic [1:0]  stall_w2, flush_w2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  hazard_unit #(.LOAD_BUBBLES(1), .CNT_W(32)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dREN(exmem_dREN),
    .exmem_dWEN(exmem_dWEN), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dMemREN(idex_dMemREN), .idex_regWEN(idex_regWEN), .idex_rt(idex_rt),
    .redirect(redirect), .memwb_halt(memwb_halt),
    .pc_en(pc_en_w[0]), .ifid_en(ifid_en_w[0]), .idex_en(idex_en_w[0]), .exmem_en(exmem_en_w[0]),
    .memwb_en(memwb_en_w[0]), .ifid_flush(ifid_flush_w[0]), .idex_flush(idex_flush_w[0]),
    .exmem_flush(exmem_flush_w[0]), .halt(halt_w[0]), .stall_cycles(stall_w0),
    .flush_events(flush_w0), .dbg_state(state_w0));

  hazard_unit #(.LOAD_BUBBLES(2), .CNT_W(32)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dREN(exmem_dREN),
    .exmem_dWEN(exmem_dWEN), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dMemREN(idex_dMemREN), .idex_regWEN(idex_regWEN), .idex_rt(idex_rt),
    .redirect(redirect), .memwb_halt(memwb_halt),
    .pc_en(pc_en_w[1]), .ifid_en(ifid_en_w[1]), .idex_en(idex_en_w[1]), .exmem_en(exmem_en_w[1]),
    .memwb_en(memwb_en_w[1]), .ifid_flush(ifid_flush_w[1]), .idex_flush(idex_flush_w[1]),
    .exmem_flush(exmem_flush_w[1]), .halt(halt_w[1]), .stall_cycles(stall_w1),
    .flush_events(flush_w1), .dbg_state(state_w1));

  hazard_unit #(.LOAD_BUBBLES(1), .CNT_W(2)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dREN(exmem_dREN),
    .exmem_dWEN(exmem_dWEN), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_dMemREN(idex_dMemREN), .idex_regWEN(idex_regWEN), .idex_rt(idex_rt),
    .redirect(redirect), .memwb_halt(memwb_halt),
    .pc_en(pc_en_w[2]), .ifid_en(ifid_en_w[2]), .idex_en(idex_en_w[2]), .exmem_en(exmem_en_w[2]),
    .memwb_en(memwb_en_w[2]), .ifid_flush(ifid_flush_w[2]), .idex_flush(idex_flush_w[2]),
    .exmem_flush(exmem_flush_w[2]), .halt(halt_w[2]), .stall_cycles(stall_w2),
    .flush_events(flush_w2), .dbg_state(state_w2));

  // ---------------- reference model: bubbles still owed per instance ----------------
  localparam logic [7:0] E_FREEZE   = 8'b0000_0000;
  localparam logic [7:0] E_ADVANCE  = 8'b1111_1000;
  localparam logic [7:0] E_REDIRECT = 8'b1111_1110;
  localparam logic [7:0] E_BUBBLE   = 8'b0011_1010;
  localparam logic [7:0] E_FETCH    = 8'b0111_1100;

  int     m_bub[3] = '{1, 2, 1};
  longint m_cap[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};
  int     m_left[3];
  bit     m_halted[3];
  longint m_stall[3];
  longint m_flush[3];

  function automatic bit mdl_busy();
    return (exmem_dREN || exmem_dWEN) && !dhit;
  endfunction

  function automatic bit mdl_load_use();
    return idex_dMemREN && idex_regWEN && (idex_rt != 0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  endfunction

  function automatic logic [7:0] exp_ctrl(int i);
    if (!nRST || m_halted[i] || memwb_halt || mdl_busy()) return E_FREEZE;
    if (redirect) return E_REDIRECT;
    if (m_left[i] > 0 || mdl_load_use()) return E_BUBBLE;
    if (!ihit) return E_FETCH;
    return E_ADVANCE;
  endfunction

  function automatic logic [1:0] exp_state(int i);
    if (m_halted[i]) return HALTED;
    if (m_left[i] > 0) return LU_STALL;
    return RUN;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0; m_halted[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  task automatic model_advance(int i, logic [7:0] c);
    if (!nRST || m_halted[i]) return;
    if (!c[7] && m_stall[i] < m_cap[i]) m_stall[i]++;
    if (memwb_halt) m_halted[i] = 1;
    else if (mdl_busy()) ;
    else if (redirect) begin
      m_left[i] = 0;
      if (m_flush[i] < m_cap[i]) m_flush[i]++;
    end
    else if (m_left[i] > 0) m_left[i]--;
    else if (mdl_load_use()) m_left[i] = m_bub[i] - 1;
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] act_ctrl(int i);
    return {pc_en_w[i], ifid_en_w[i], idex_en_w[i], exmem_en_w[i], memwb_en_w[i],
            ifid_flush_w[i], idex_flush_w[i], exmem_flush_w[i], halt_w[i]};
  endfunction

  function automatic logic [31:0] act_stall(int i);
    case (i)
      0: return stall_w0;
      1: return stall_w1;
      default: return {30'd0, stall_w2};
    endcase
  endfunction

  function automatic logic [31:0] act_flush(int i);
    case (i)
      0: return flush_w0;
      1: return flush_w1;
      default: return {30'd0, flush_w2};
    endcase
  endfunction

  function automatic logic [1:0] act_state(int i);
    case (i)
      0: return state_w0;
      1: return state_w1;
      default: return state_w2;
    endcase
  endfunction

  // Sample at the falling edge, compare every instance, then advance the model.
  task automatic sample();
    logic [7:0] c;
    @(negedge CLK);
    if (!nRST) model_reset();
    for (int i = 0; i < 3; i++) begin
      c = exp_ctrl(i);
      check($sformatf("ctrl%0d", i), {23'd0, act_ctrl(i)}, {23'd0, c, m_halted[i]});
      check($sformatf("state%0d", i), {30'd0, act_state(i)}, {30'd0, exp_state(i)});
      check($sformatf("stall%0d", i), act_stall(i), m_stall[i][31:0]);
      check($sformatf("flush%0d", i), act_flush(i), m_flush[i][31:0]);
      model_advance(i, c);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1; dhit = 1; exmem_dREN = 0; exmem_dWEN = 0;
    ifid_rs = 5'd1; ifid_rt = 5'd2; ifid_uses_rt = 0;
    idex_dMemREN = 0; idex_regWEN = 0; idex_rt = 5'd0;
    redirect = 0; memwb_halt = 0;
  endtask

  task automatic set_load_use(logic [4:0] r);
    idex_dMemREN = 1; idex_regWEN = 1; idex_rt = r; ifid_rs = r;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    sample();
    next();
    nRST = 1;
  endtask

  // ---------------- table vectors (checked against the 1-bubble instance) ----------------
  typedef struct {
    logic       ihit, dhit, dren, dwen;
    logic [4:0] rs, rt;
    logic       uses_rt, mren, rwen;
    logic [4:0] idrt;
    logic       redir;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] s0;
    logic [31:0] s1;
    vecs[0]  = '{1,1,0,0, 5'd1,5'd2, 0,0,0, 5'd0, 0, E_ADVANCE};
    vecs[1]  = '{0,1,0,0, 5'd1,5'd2, 0,0,0, 5'd0, 0, E_FETCH};
    vecs[2]  = '{1,1,0,0, 5'd5,5'd2, 0,1,1, 5'd5, 0, E_BUBBLE};
    vecs[3]  = '{1,1,0,0, 5'd1,5'd7, 1,1,1, 5'd7, 0, E_BUBBLE};
    vecs[4]  = '{1,1,0,0, 5'd1,5'd7, 0,1,1, 5'd7, 0, E_ADVANCE};
    vecs[5]  = '{1,1,0,0, 5'd0,5'd0, 1,1,1, 5'd0, 0, E_ADVANCE};
    vecs[6]  = '{1,1,0,0, 5'd5,5'd2, 0,1,0, 5'd5, 0, E_ADVANCE};
    vecs[7]  = '{1,0,1,0, 5'd1,5'd2, 0,0,0, 5'd0, 0, E_FREEZE};
    vecs[8]  = '{1,0,0,1, 5'd1,5'd2, 0,0,0, 5'd0, 0, E_FREEZE};
    vecs[9]  = '{1,1,1,0, 5'd1,5'd2, 0,0,0, 5'd0, 0, E_ADVANCE};
    vecs[10] = '{0,1,0,0, 5'd1,5'd2, 0,0,0, 5'd0, 1, E_REDIRECT};
    vecs[11] = '{1,1,0,0, 5'd9,5'd2, 0,1,1, 5'd9, 1, E_REDIRECT};
    vecs[12] = '{1,0,1,0, 5'd1,5'd2, 0,0,0, 5'd0, 1, E_FREEZE};
    vecs[13] = '{0,1,0,0, 5'd4,5'd2, 0,1,1, 5'd4, 0, E_BUBBLE};

    // Reset, then idle with everything advancing and counters at zero.
    do_reset();
    sample();
    check("idle_ctrl", {24'd0, act_ctrl(0)[8:1]}, {24'd0, E_ADVANCE});
    check("idle_stall", stall_w0, 32'd0);
    next();

    for (int v = 0; v < 14; v++) begin
      ihit = vecs[v].ihit; dhit = vecs[v].dhit;
      exmem_dREN = vecs[v].dren; exmem_dWEN = vecs[v].dwen;
      ifid_rs = vecs[v].rs; ifid_rt = vecs[v].rt; ifid_uses_rt = vecs[v].uses_rt;
      idex_dMemREN = vecs[v].mren; idex_regWEN = vecs[v].rwen; idex_rt = vecs[v].idrt;
      redirect = vecs[v].redir; memwb_halt = 0;
      sample();
      check($sformatf("tbl%0d", v), {24'd0, act_ctrl(0)[8:1]}, {24'd0, vecs[v].exp});
      next();
      idle_inputs();
      sample();
      next();
      sample();
      next();
    end

    // Single load-use: one bubble on the 1-bubble instance, two on the 2-bubble one.
    do_reset();
    set_load_use(5'd5);
    sample();
    check("lu1_c1_dut0", {24'd0, act_ctrl(0)[8:1]}, {24'd0, E_BUBBLE});
    next();
    idle_inputs();
    sample();
    check("lu1_c2_dut0", {24'd0, act_ctrl(0)[8:1]}, {24'd0, E_ADVANCE});
    check("lu1_c2_dut1", {24'd0, act_ctrl(1)[8:1]}, {24'd0, E_BUBBLE});
    check("lu1_stall_dut0", stall_w0, 32'd1);
    next();
    sample();
    check("lu1_c3_dut1", {24'd0, act_ctrl(1)[8:1]}, {24'd0, E_ADVANCE});
    check("lu1_stall_dut1", stall_w1, 32'd2);
    next();

    // 2-bubble hazard with a memory freeze between the bubbles.
    do_reset();
    set_load_use(5'd5);
    sample();
    next();
    idle_inputs();
    exmem_dREN = 1; dhit = 0;
    sample();
    check("lu2_freeze", {24'd0, act_ctrl(1)[8:1]}, {24'd0, E_FREEZE});
    check("lu2_freeze_state", {30'd0, state_w1}, {30'd0, LU_STALL});
    next();
    idle_inputs();
    sample();
    check("lu2_bubble2", {24'd0, act_ctrl(1)[8:1]}, {24'd0, E_BUBBLE});
    next();
    sample();
    check("lu2_resume", {24'd0, act_ctrl(1)[8:1]}, {24'd0, E_ADVANCE});
    check("lu2_stall", stall_w1, 32'd3);
    next();

    // Redirect and load-use together.
    do_reset();
    set_load_use(5'd6);
    redirect = 1;
    sample();
    check("redir_lu_ctrl", {24'd0, act_ctrl(1)[8:1]}, {24'd0, E_REDIRECT});
    next();
    idle_inputs();
    sample();
    check("redir_lu_flush", flush_w0, 32'd1);
    check("redir_lu_state", {30'd0, state_w1}, {30'd0, RUN});
    next();

    // Three fetch misses.
    do_reset();
    ihit = 0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("ihit0_ctrl", {24'd0, act_ctrl(0)[8:1]}, {24'd0, E_FETCH});
      next();
    end
    idle_inputs();
    sample();
    check("ihit0_stall", stall_w0, 32'd3);
    next();

    // Randomized traffic; the 2-bit counter instance saturates along the way.
    for (int k = 0; k < 1500; k++) begin
      ihit = ($urandom_range(0, 99) < 85);
      dhit = $urandom_range(0, 1);
      exmem_dREN = ($urandom_range(0, 99) < 20);
      exmem_dWEN = ($urandom_range(0, 99) < 10);
      ifid_rs = 5'($urandom_range(0, 7));
      ifid_rt = 5'($urandom_range(0, 7));
      ifid_uses_rt = $urandom_range(0, 1);
      idex_dMemREN = ($urandom_range(0, 99) < 40);
      idex_regWEN = ($urandom_range(0, 99) < 80);
      idex_rt = 5'($urandom_range(0, 7));
      redirect = ($urandom_range(0, 99) < 10);
      memwb_halt = 0;
      sample();
      next();
    end
    idle_inputs();
    sample();
    check("sat_stall", {30'd0, stall_w2}, 32'd3);
    check("sat_flush", {30'd0, flush_w2}, 32'd3);
    next();

    // Halt pulse: freeze, sticky halt, frozen counters, cleared by reset.
    memwb_halt = 1;
    sample();
    check("halt_entry", {24'd0, act_ctrl(0)[8:1]}, {24'd0, E_FREEZE});
    next();
    memwb_halt = 0;
    s0 = stall_w0;
    s1 = flush_w0;
    for (int k = 0; k < 4; k++) begin
      ihit = k[0];
      redirect = k[1];
      sample();
      check("halt_sticky", {31'd0, halt_w[0]}, 32'd1);
      check("halt_stall_frozen", stall_w0, s0);
      check("halt_flush_frozen", flush_w0, s1);
      next();
    end
    idle_inputs();
    nRST = 0;
    sample();
    check("halt_cleared", {31'd0, halt_w[0]}, 32'd0);
    check("halt_rst_stall", stall_w0, 32'd0);
    next();
    nRST = 1;
    sample();
    next();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline control block that consumes the decoded ID/EX latch contents, the IF/ID source registers and the memory handshakes. It drives the enable and flush inputs of the PC and of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB). It handles load-use bubbles, memory-wait freezes, branch/jump redirects and halt. It also keeps saturating stall and flush performance counters.

Parameters:
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3; 2 when MEM->EX forwarding is absent)
CNT_W, 32, width of the performance counters

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction word valid this cycle
dhit  in  1  data access completes this cycle
exmem_dREN  in  1  MEM stage holds a load
exmem_dWEN  in  1  MEM stage holds a store
ifid_rs  in  5  rs field of the instruction in IF/ID
ifid_rt  in  5  rt field of the instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, BEQ/BNE)
idex_dMemREN  in  1  ID/EX holds a load
idex_regWEN  in  1  ID/EX writes a register
idex_rt  in  5  load destination register in ID/EX
redirect  in  1  EX/MEM resolved a taken branch, J, JAL or JR
memwb_halt  in  1  HALT reached MEM/WB
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (zeros) into the latch; asserted only together with its enable
halt  out  1  sticky processor halted
stall_cycles  out  CNT_W  cycles with pc_en=0 while not halted
flush_events  out  CNT_W  redirects taken

Behaviour:
- Internal signals:
  - mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit
  - lu_hit = idex_dMemREN & idex_regWEN & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt))
- Reset (nRST=0, asynchronous):
  - state RUN, bubble counter 0, halt 0, both counters 0.
  - All enables and flushes are forced to 0 combinationally while nRST is low.
- States: RUN, LU_STALL, HALTED. Enables and flushes are combinational from state and inputs. State, halt and counters are registered.
- Per-cycle priority, highest first:
  1. HALTED: all enables 0, all flushes 0, halt=1. No exit except reset.
  2. memwb_halt (RUN or LU_STALL): all enables 0 this cycle; next state HALTED, halt=1 from the next edge.
  3. mem_busy: all enables 0 (full freeze). State and bubble counter hold.
  4. redirect: pc_en=1, ifid_en=ifid_flush=1, idex_en=idex_flush=1, exmem_en=memwb_en=1. Applies regardless of ihit. Clears any LU_STALL, next state RUN, flush_events+1.
  5. lu_hit in RUN:
     - pc_en=0, ifid_en=0, idex_en=idex_flush=1, exmem_en=memwb_en=1.
     - LOAD_BUBBLES=1: stay RUN.
     - Otherwise: go to LU_STALL with counter=LOAD_BUBBLES-1.
  6. LU_STALL: same outputs as rule 5 regardless of lu_hit. Counter decrements; when it is 1 on an advancing cycle, the next state is RUN.
  7. ~ihit: pc_en=0, ifid_en=ifid_flush=1, rest advance.
  8. Otherwise: all enables 1, flushes 0.
- exmem_flush is 0 in all current rules; it is reserved and must be tied 0.
- stall_cycles increments on every non-HALTED, post-reset cycle with pc_en=0, mem_busy freezes included.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- redirect and lu_hit in the same cycle: redirect wins. The dependent instruction is wrong-path and is flushed.

Decomposition:
- Add hazard_state_t enum {RUN, LU_STALL, HALTED} to cpu_types_pkg.
- The sub-module sat_counter (parameter W; inputs CLK, nRST, inc; output count) is instantiated twice.

Test Plan:
- Reset then idle, ihit=1, no hazards:
  - all enables 1, flushes 0, counters 0.
- Load-use:
  - idex_dMemREN=1, idex_regWEN=1, idex_rt=5, ifid_rs=5.
  - Expect one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal.
  - stall_cycles=1.
  - With idex_rt=0: no stall.
- LOAD_BUBBLES=2, same hazard:
  - two consecutive bubble cycles.
  - Inject dhit=0 with exmem_dREN=1 in the middle: full freeze for that cycle, bubble count preserved, 3 stall cycles total.
- redirect=1 and lu_hit=1 in the same cycle:
  - pc_en=1, ifid_flush=1, idex_flush=1, flush_events=1, state RUN.
- ihit=0 for 3 cycles:
  - ifid_flush=1 each cycle, downstream enables 1, stall_cycles=3.
- memwb_halt=1 pulse for one cycle:
  - all enables 0, halt=1 from the next edge and held after memwb_halt drops.
  - Counters frozen until nRST low, then halt=0.
